tlul_host_adapter: RTL and testbench

Initiator-side TL-UL bridge that turns a simple req/gnt host memory interface (core LSU, DMA, debug master) into TL-UL A-channel requests and returns D-channel responses to the host. It is the host end of the TL-UL links that device-side blocks buffer with the synchronous FIFOs. It sits between a host and the crossbar. It bounds outstanding transactions, assigns `a_source` tags and checks the response ordering.

---
 rtl/tlul_pkg.sv | 49 ++++
 rtl/tlul_tag_counter.sv | 32 +++
 rtl/tlul_host_adapter.sv | 130 +++++++++++++
 tb/tb_tlul_host_adapter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// TL-UL type definitions shared by hosts and devices: channel structs, opcode enums and the bus
// width constants. The host adapter only consumes this package and adds nothing to it.
package tlul_pkg;

  localparam int unsigned TlAw  = 32;        // address width
  localparam int unsigned TlDw  = 32;        // data width
  localparam int unsigned TlDbw = TlDw / 8;  // mask width
  localparam int unsigned TlSzw = 2;         // size field width
  localparam int unsigned TlAiw = 8;         // source id width
  localparam int unsigned TlDiw = 1;         // sink id width

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  // Host to device: A channel plus D-channel ready.
  typedef struct packed {
    logic             a_valid;
    tl_a_op_e         a_opcode;
    logic [2:0]       a_param;
    logic [TlSzw-1:0] a_size;
    logic [TlAiw-1:0] a_source;
    logic [TlAw-1:0]  a_address;
    logic [TlDbw-1:0] a_mask;
    logic [TlDw-1:0]  a_data;
    logic             d_ready;
  } tl_h2d_t;

  // Device to host: D channel plus A-channel ready.
  typedef struct packed {
    logic             d_valid;
    tl_d_op_e         d_opcode;
    logic [2:0]       d_param;
    logic [TlSzw-1:0] d_size;
    logic [TlAiw-1:0] d_source;
    logic [TlDiw-1:0] d_sink;
    logic [TlDw-1:0]  d_data;
    logic             d_error;
    logic             a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_tag_counter.sv
// Transaction tag counter: counts 0..Max-1 and wraps to 0, advancing on each incr pulse.
// Ports: clock, reset (async active-low), incr (advance), value (current tag).
module tlul_tag_counter #(
  parameter int unsigned Max   = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             incr,
  output logic [Width-1:0] value
);

  logic [Width-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (incr) begin
      value_d = (value_q == Width'(Max - 1)) ? '0 : value_q + Width'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/tlul_host_adapter.sv
// Host-side TL-UL bridge: converts a req/gnt host memory port into TL-UL A-channel requests,
// bounds the number in flight, tags them with a_source and returns in-order D responses as a
// single-cycle valid pulse with registered rdata/err.
// Ports: clock, reset (async active-low); host side req_i/gnt_o/addr_i/we_i/wdata_i/be_i and
// valid_o/rdata_o/err_o; bus side tl_o (A channel + d_ready), tl_i (D channel + a_ready).
// Build option: define TLUL_HOST_SRC_CHECK_EN to flag responses whose d_source does not match
// the expected in-order tag.
module tlul_host_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned      MaxOutstanding = 2,  // 1..16
  parameter logic [TlAiw-1:0] SrcBase        = '0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned TagW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [CntW-1:0] cnt_d, cnt_q;
  logic [TagW-1:0] wtag, rtag;
  logic            full, a_valid, a_hs, d_rsp;
  logic            valid_q, err_q, err_d, src_err;
  logic [31:0]     rdata_q, rdata_d;

  assign full    = (cnt_q == CntW'(MaxOutstanding));
  assign a_valid = req_i & ~full;
  assign a_hs    = a_valid & tl_i.a_ready;
  assign gnt_o   = a_hs;
  // d_ready is tied high, so d_valid alone is a handshake. Beats with nothing in flight are
  // swallowed without touching any state.
  assign d_rsp   = tl_i.d_valid & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    case ({a_hs, d_rsp})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  tlul_tag_counter #(
    .Max   (MaxOutstanding),
    .Width (TagW)
  ) u_wtag (
    .clock (clock),
    .reset (reset),
    .incr  (a_hs),
    .value (wtag)
  );

  tlul_tag_counter #(
    .Max   (MaxOutstanding),
    .Width (TagW)
  ) u_rtag (
    .clock (clock),
    .reset (reset),
    .incr  (d_rsp),
    .value (rtag)
  );

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid;
    if (!we_i) begin
      tl_o.a_opcode = Get;
    end else if (be_i == 4'hF) begin
      tl_o.a_opcode = PutFullData;
    end else begin
      tl_o.a_opcode = PutPartialData;
    end
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = TlSzw'(2);
    tl_o.a_source  = SrcBase + TlAiw'(wtag);
    tl_o.a_address = {addr_i[31:2], 2'b00};
    tl_o.a_mask    = we_i ? be_i : 4'hF;
    tl_o.a_data    = we_i ? wdata_i : '0;
    tl_o.d_ready   = 1'b1;
  end

`ifdef TLUL_HOST_SRC_CHECK_EN
  assign src_err = (tl_i.d_source != (SrcBase + TlAiw'(rtag)));
`else
  logic unused_src;
  logic unused_rtag;
  assign src_err     = 1'b0;
  assign unused_src  = ^tl_i.d_source;
  assign unused_rtag = ^rtag;
`endif

  assign rdata_d = (tl_i.d_opcode == AccessAckData) ? tl_i.d_data : '0;
  assign err_d   = tl_i.d_error | src_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= d_rsp;
      if (d_rsp) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

  logic unused_tl;
  assign unused_tl = ^{addr_i[1:0], tl_i.d_param, tl_i.d_size, tl_i.d_sink};

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed bench for tlul_host_adapter (MaxOutstanding=2, SrcBase=0): a cycle-by-cycle vector
// table followed by hand-written backpressure, wrap, source-check and reset sequences.
module tb_tlul_host_adapter;
  import tlul_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req, gnt, we, valid, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  tlul_host_adapter #(
    .MaxOutstanding (2),
    .SrcBase        (8'h00)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req_i   (req),
    .gnt_o   (gnt),
    .addr_i  (addr),
    .we_i    (we),
    .wdata_i (wdata),
    .be_i    (be),
    .valid_o (valid),
    .rdata_o (rdata),
    .err_o   (err),
    .tl_o    (tl_o),
    .tl_i    (tl_i)
  );

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        a_ready;
    logic        d_valid;
    tl_d_op_e    d_op;
    logic [31:0] d_data;
    logic        d_error;
    logic [7:0]  d_source;
    logic        e_gnt;
    logic        e_av;
    tl_a_op_e    e_op;
    logic [31:0] e_addr;
    logic [3:0]  e_mask;
    logic [31:0] e_data;
    logic [7:0]  e_src;
    logic        e_valid;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[9];

`ifdef TLUL_HOST_SRC_CHECK_EN
  localparam logic ExpSrcErr = 1'b1;
`else
  localparam logic ExpSrcErr = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    be    = '0;
    tl_i  = '0;
    tl_i.a_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic d_beat(input tl_d_op_e op, input logic [31:0] data, input logic [7:0] src);
    tl_i.d_valid  = 1'b1;
    tl_i.d_opcode = op;
    tl_i.d_data   = data;
    tl_i.d_source = src;
    tl_i.d_error  = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #12;
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_a_valid", 32'(tl_o.a_valid), 32'h0);
    chk("d_ready", 32'(tl_o.d_ready), 32'h1);

    //           req   we    addr          wdata         be    ar    dv    d_op           d_data        derr  dsrc
    //           gnt   av    op              a_addr        mask  a_data        src    valid rdata        err
    vecs[0] = '{1'b1, 1'b0, 32'h0000_1003, 32'h0, 4'h0, 1'b1, 1'b0, AccessAck, 32'h0, 1'b0, 8'h0,
                1'b1, 1'b1, Get, 32'h0000_1000, 4'hF, 32'h0, 8'h0, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, AccessAckData, 32'hDEAD_BEEF, 1'b0, 8'h0,
                1'b0, 1'b0, Get, 32'h0, 4'hF, 32'h0, 8'h1, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF, 1'b1, 1'b0, AccessAck, 32'h0, 1'b0,
                8'h0, 1'b1, 1'b1, PutFullData, 32'h0000_2000, 4'hF, 32'h1234_5678, 8'h1, 1'b0,
                32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_2006, 32'hAABB_CCDD, 4'h3, 1'b1, 1'b1, AccessAck, 32'h9999_9999,
                1'b0, 8'h1, 1'b1, 1'b1, PutPartialData, 32'h0000_2004, 4'h3, 32'hAABB_CCDD, 8'h0,
                1'b1, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_3000, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b0, AccessAck, 32'h0, 1'b0,
                8'h0, 1'b0, 1'b1, Get, 32'h0000_3000, 4'hF, 32'h0, 8'h1, 1'b0, 32'h0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, AccessAckData, 32'h55, 1'b1, 8'h0,
                1'b0, 1'b0, Get, 32'h0, 4'hF, 32'h0, 8'h1, 1'b1, 32'h55, 1'b1};
    // Spurious beat: nothing in flight, outputs and tags must not move.
    vecs[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, AccessAckData, 32'h77, 1'b0, 8'h1,
                1'b0, 1'b0, Get, 32'h0, 4'hF, 32'h0, 8'h1, 1'b0, 32'h55, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 4'h8, 1'b1, 1'b0, AccessAck, 32'h0, 1'b0,
                8'h0, 1'b1, 1'b1, PutPartialData, 32'h0000_0004, 4'h8, 32'hCAFE_F00D, 8'h1, 1'b0,
                32'h55, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, AccessAck, 32'h0, 1'b0, 8'h1,
                1'b0, 1'b0, Get, 32'h0, 4'hF, 32'h0, 8'h0, 1'b1, 32'h0, 1'b0};

    @(negedge clock);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      req           = vecs[i].req;
      we            = vecs[i].we;
      addr          = vecs[i].addr;
      wdata         = vecs[i].wdata;
      be            = vecs[i].be;
      tl_i.a_ready  = vecs[i].a_ready;
      tl_i.d_valid  = vecs[i].d_valid;
      tl_i.d_opcode = vecs[i].d_op;
      tl_i.d_data   = vecs[i].d_data;
      tl_i.d_error  = vecs[i].d_error;
      tl_i.d_source = vecs[i].d_source;
      #3;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
      chk($sformatf("v%0d_a_valid", i), 32'(tl_o.a_valid), 32'(vecs[i].e_av));
      chk($sformatf("v%0d_opcode", i), 32'(tl_o.a_opcode), 32'(vecs[i].e_op));
      chk($sformatf("v%0d_address", i), tl_o.a_address, vecs[i].e_addr);
      chk($sformatf("v%0d_mask", i), 32'(tl_o.a_mask), 32'(vecs[i].e_mask));
      chk($sformatf("v%0d_a_data", i), tl_o.a_data, vecs[i].e_data);
      chk($sformatf("v%0d_source", i), 32'(tl_o.a_source), 32'(vecs[i].e_src));
      chk($sformatf("v%0d_size", i), 32'(tl_o.a_size), 32'h2);
      tick();
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e_err));
    end
    idle();

    // Backpressure: two grants fill the adapter; a D beat frees a slot only from the next cycle.
    do_reset();
    idle();
    req  = 1'b1;
    addr = 32'h40;
    for (int c = 0; c < 4; c++) begin
      #3;
      chk($sformatf("bp%0d_gnt", c), 32'(gnt), (c < 2) ? 32'h1 : 32'h0);
      chk($sformatf("bp%0d_a_valid", c), 32'(tl_o.a_valid), (c < 2) ? 32'h1 : 32'h0);
      if (c < 2) chk($sformatf("bp%0d_src", c), 32'(tl_o.a_source), 32'(c));
      tick();
    end
    d_beat(AccessAckData, 32'h11, 8'h0);
    #3;
    chk("bp_gnt_with_dbeat", 32'(gnt), 32'h0);
    tick();
    tl_i.d_valid = 1'b0;
    chk("bp_rsp_valid", 32'(valid), 32'h1);
    chk("bp_rsp_rdata", rdata, 32'h11);
    #3;
    chk("bp_third_gnt", 32'(gnt), 32'h1);
    chk("bp_third_src", 32'(tl_o.a_source), 32'h0);
    tick();
    idle();

    // Wrap-around: five back-to-back requests, each response returned in order the next cycle.
    do_reset();
    idle();
    for (int k = 0; k < 6; k++) begin
      req  = (k < 5);
      addr = 32'(k * 4);
      if (k >= 1) d_beat(AccessAckData, 32'(k), 8'((k - 1) % 2));
      else tl_i.d_valid = 1'b0;
      #3;
      if (k < 5) begin
        chk($sformatf("wrap%0d_gnt", k), 32'(gnt), 32'h1);
        chk($sformatf("wrap%0d_src", k), 32'(tl_o.a_source), 32'(k % 2));
      end
      tick();
      if (k >= 1) begin
        chk($sformatf("wrap%0d_valid", k), 32'(valid), 32'h1);
        chk($sformatf("wrap%0d_err", k), 32'(err), 32'h0);
        chk($sformatf("wrap%0d_rdata", k), rdata, 32'(k));
      end
    end
    idle();
    tick();

    // Wrong d_source: flagged only with the source check built in, but it always retires.
    do_reset();
    idle();
    req = 1'b1;
    #3;
    chk("src_gnt0", 32'(gnt), 32'h1);
    tick();
    req = 1'b0;
    d_beat(AccessAckData, 32'h1, 8'h1);
    tick();
    tl_i.d_valid = 1'b0;
    chk("src_valid", 32'(valid), 32'h1);
    chk("src_err", 32'(err), 32'(ExpSrcErr));
    req = 1'b1;
    #3;
    chk("src_gnt1", 32'(gnt), 32'h1);
    chk("src_src1", 32'(tl_o.a_source), 32'h1);
    tick();
    #3;
    chk("src_gnt2_retired", 32'(gnt), 32'h1);
    tick();
    #3;
    chk("src_full", 32'(gnt), 32'h0);
    req = 1'b0;

    // Reset with two requests in flight; later D beats are spurious.
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    d_beat(AccessAckData, 32'hBAD0_BAD0, 8'h0);
    tick();
    tl_i.d_valid = 1'b0;
    chk("post_rst_spurious_valid", 32'(valid), 32'h0);
    chk("post_rst_spurious_rdata", rdata, 32'h0);
    req = 1'b1;
    #3;
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    chk("post_rst_src", 32'(tl_o.a_source), 32'h0);
    tick();
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
